// File: rtl/reg_file_rd_server_if.sv
// Bus bundle for reg_file_rd_server: two read-port handshakes
// (addr/en -> data/st), the write-back write port and the reserve port.
// The responder uses the slave modport; the requester side uses master.
interface reg_file_rd_server_if #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
);
  logic [REG_ADDR_LEN-1:0] Rd1_addr;
  logic                    Rd1_en;
  logic [WIDTH-1:0]        Rd1_data;
  logic                    Rd1_st;

  logic [REG_ADDR_LEN-1:0] Rd2_addr;
  logic                    Rd2_en;
  logic [WIDTH-1:0]        Rd2_data;
  logic                    Rd2_st;

  logic [REG_ADDR_LEN-1:0] Wr_addr;
  logic [WIDTH-1:0]        Wr_data;
  logic                    Wr_en;

  logic [REG_ADDR_LEN-1:0] Rsv_addr;
  logic                    Rsv_en;

  modport master (
    output Rd1_addr, Rd1_en, input Rd1_data, Rd1_st,
    output Rd2_addr, Rd2_en, input Rd2_data, Rd2_st,
    output Wr_addr, Wr_data, Wr_en,
    output Rsv_addr, Rsv_en
  );

  modport slave (
    input Rd1_addr, Rd1_en, output Rd1_data, Rd1_st,
    input Rd2_addr, Rd2_en, output Rd2_data, Rd2_st,
    input Wr_addr, Wr_data, Wr_en,
    input Rsv_addr, Rsv_en
  );
endinterface

// File: rtl/reg_file_rd_server.sv
// Register file responder with a per-register pending scoreboard.
// R0 reads as zero and ignores writes. Each of the two read ports runs a
// small IDLE/WAIT FSM: a read of a pending register parks in WAIT until the
// write-back stage writes that register.
// Optional feature macro: REGFILE_BYPASS_EN -- forwards same-edge write data
// straight to a read of the same register (including a waiting read).
module reg_file_rd_server #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input logic                clk,
  input logic                rst_n,
  reg_file_rd_server_if.slave bus
);

  localparam int NPORT = 2;
  localparam int DEPTH = 2 ** REG_ADDR_LEN;
  localparam logic [REG_ADDR_LEN-1:0] ADDR_ZERO = {REG_ADDR_LEN{1'b0}};
  localparam logic [WIDTH-1:0]        DATA_ZERO = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

  // Storage and scoreboard
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Per-port read FSM state
  rd_state_e               state_q [NPORT];
  rd_state_e               state_d [NPORT];
  logic [REG_ADDR_LEN-1:0] lat_q   [NPORT];
  logic [REG_ADDR_LEN-1:0] lat_d   [NPORT];
  logic [WIDTH-1:0]        data_q  [NPORT];
  logic [WIDTH-1:0]        data_d  [NPORT];
  logic                    st_q    [NPORT];
  logic                    st_d    [NPORT];

  // Port inputs gathered into arrays so both FSMs share one description
  logic [REG_ADDR_LEN-1:0] rd_addr_s [NPORT];
  logic                    rd_en_s   [NPORT];
  logic                    wr_live_s;
  logic                    rsv_live_s;

  assign rd_addr_s[0] = bus.Rd1_addr;
  assign rd_addr_s[1] = bus.Rd2_addr;
  assign rd_en_s[0]   = bus.Rd1_en;
  assign rd_en_s[1]   = bus.Rd2_en;

  // Writes and reserves to R0 are dropped at the source
  assign wr_live_s  = bus.Wr_en  && (bus.Wr_addr  != ADDR_ZERO);
  assign rsv_live_s = bus.Rsv_en && (bus.Rsv_addr != ADDR_ZERO);

  assign bus.Rd1_data = data_q[0];
  assign bus.Rd1_st   = st_q[0];
  assign bus.Rd2_data = data_q[1];
  assign bus.Rd2_st   = st_q[1];

  // Next register contents and scoreboard: a reserve on the same edge as a write wins
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    pend_d = pend_q;
    if (wr_live_s) begin
      mem_d[bus.Wr_addr]  = bus.Wr_data;
      pend_d[bus.Wr_addr] = 1'b0;
    end else begin
      pend_d = pend_d;
    end
    if (rsv_live_s) begin
      pend_d[bus.Rsv_addr] = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  // Read FSMs: strobe is a single-cycle pulse, data holds between strobes
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      state_d[p] = state_q[p];
      lat_d[p]   = lat_q[p];
      data_d[p]  = data_q[p];
      st_d[p]    = 1'b0;
      case (state_q[p])
        RD_IDLE: begin
          if (!rd_en_s[p]) begin
            st_d[p] = 1'b0;
          end else if (rd_addr_s[p] == ADDR_ZERO) begin
            data_d[p] = DATA_ZERO;
            st_d[p]   = 1'b1;
`ifdef REGFILE_BYPASS_EN
          end else if (wr_live_s && (bus.Wr_addr == rd_addr_s[p])) begin
            // Same-edge write to the requested register: forward it, pending or not
            data_d[p] = bus.Wr_data;
            st_d[p]   = 1'b1;
`endif
          end else if (pend_q[rd_addr_s[p]]) begin
            lat_d[p]   = rd_addr_s[p];
            state_d[p] = RD_WAIT;
          end else begin
            data_d[p] = mem_q[rd_addr_s[p]];
            st_d[p]   = 1'b1;
          end
        end
        RD_WAIT: begin
          if (!pend_q[lat_q[p]]) begin
            data_d[p]  = mem_q[lat_q[p]];
            st_d[p]    = 1'b1;
            state_d[p] = RD_IDLE;
`ifdef REGFILE_BYPASS_EN
          end else if (wr_live_s && (bus.Wr_addr == lat_q[p])) begin
            // Release on the write edge itself rather than one cycle later
            data_d[p]  = bus.Wr_data;
            st_d[p]    = 1'b1;
            state_d[p] = RD_IDLE;
`endif
          end else begin
            state_d[p] = RD_WAIT;
          end
        end
        default: begin
          state_d[p] = RD_IDLE;
        end
      endcase
    end
  end

  // Register file and scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_ZERO;
      end
      pend_q <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // Read port FSM state and registered outputs; reset aborts any waiting request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NPORT; p++) begin
        state_q[p] <= RD_IDLE;
        lat_q[p]   <= ADDR_ZERO;
        data_q[p]  <= DATA_ZERO;
        st_q[p]    <= 1'b0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        state_q[p] <= state_d[p];
        lat_q[p]   <= lat_d[p];
        data_q[p]  <= data_d[p];
        st_q[p]    <= st_d[p];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_rd_server.sv
// Directed bench for reg_file_rd_server. Inputs change 1 time unit after a
// rising edge; outputs are checked at that same point, i.e. they reflect
// the edge just taken. Expected values follow the build (REGFILE_BYPASS_EN).
module tb_reg_file_rd_server;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  reg_file_rd_server_if #(.WIDTH(32), .REG_ADDR_LEN(5)) bus_if ();

  reg_file_rd_server #(.WIDTH(32), .REG_ADDR_LEN(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    bus_if.Rd1_addr = 5'd0; bus_if.Rd1_en = 1'b0;
    bus_if.Rd2_addr = 5'd0; bus_if.Rd2_en = 1'b0;
    bus_if.Wr_addr  = 5'd0; bus_if.Wr_data = 32'h0; bus_if.Wr_en = 1'b0;
    bus_if.Rsv_addr = 5'd0; bus_if.Rsv_en = 1'b0;
    tick();
    tick();
    chk("rst_st1", {31'h0, bus_if.Rd1_st}, 32'h0);
    chk("rst_d1", bus_if.Rd1_data, 32'h0);
    chk("rst_st2", {31'h0, bus_if.Rd2_st}, 32'h0);
    chk("rst_d2", bus_if.Rd2_data, 32'h0);
    rst_n = 1'b1;

    // 1: read after reset, single-cycle strobe
    bus_if.Rd1_en = 1'b1; bus_if.Rd1_addr = 5'd5;
    tick();
    chk("t1_st", {31'h0, bus_if.Rd1_st}, 32'h1);
    chk("t1_data", bus_if.Rd1_data, 32'h0);
    bus_if.Rd1_en = 1'b0;
    tick();
    chk("t1_st_drop", {31'h0, bus_if.Rd1_st}, 32'h0);

    // 2: write r7, dual read; R0 write discarded
    bus_if.Wr_en = 1'b1; bus_if.Wr_addr = 5'd7; bus_if.Wr_data = 32'hDEADBEEF;
    tick();
    bus_if.Wr_en = 1'b0;
    bus_if.Rd1_en = 1'b1; bus_if.Rd1_addr = 5'd7;
    bus_if.Rd2_en = 1'b1; bus_if.Rd2_addr = 5'd7;
    tick();
    chk("t2_st1", {31'h0, bus_if.Rd1_st}, 32'h1);
    chk("t2_d1", bus_if.Rd1_data, 32'hDEADBEEF);
    chk("t2_st2", {31'h0, bus_if.Rd2_st}, 32'h1);
    chk("t2_d2", bus_if.Rd2_data, 32'hDEADBEEF);
    bus_if.Rd1_en = 1'b0; bus_if.Rd2_en = 1'b0;
    bus_if.Wr_en = 1'b1; bus_if.Wr_addr = 5'd0; bus_if.Wr_data = 32'h1234;
    tick();
    bus_if.Wr_en = 1'b0;
    bus_if.Rd1_en = 1'b1; bus_if.Rd1_addr = 5'd0;
    tick();
    chk("t2_r0_st", {31'h0, bus_if.Rd1_st}, 32'h1);
    chk("t2_r0_d", bus_if.Rd1_data, 32'h0);
    bus_if.Rd1_en = 1'b0;

    // 3: reserve r3, port 2 waits 4 cycles while port 1 keeps serving
    bus_if.Rsv_en = 1'b1; bus_if.Rsv_addr = 5'd3;
    tick();
    bus_if.Rsv_en = 1'b0;
    bus_if.Rd2_en = 1'b1; bus_if.Rd2_addr = 5'd3;
    tick();
    chk("t3_w1_st2", {31'h0, bus_if.Rd2_st}, 32'h0);
    chk("t3_w1_d2_hold", bus_if.Rd2_data, 32'hDEADBEEF);
    bus_if.Rd2_addr = 5'd7;
    bus_if.Rd1_en = 1'b1; bus_if.Rd1_addr = 5'd7;
    tick();
    chk("t3_w2_st2", {31'h0, bus_if.Rd2_st}, 32'h0);
    chk("t3_p1_st", {31'h0, bus_if.Rd1_st}, 32'h1);
    chk("t3_p1_d", bus_if.Rd1_data, 32'hDEADBEEF);
    bus_if.Rd1_en = 1'b0;
    tick();
    chk("t3_w3_st2", {31'h0, bus_if.Rd2_st}, 32'h0);
    bus_if.Rd2_en = 1'b0;
    tick();
    chk("t3_w4_st2", {31'h0, bus_if.Rd2_st}, 32'h0);
    bus_if.Wr_en = 1'b1; bus_if.Wr_addr = 5'd3; bus_if.Wr_data = 32'h55;
    tick();
    bus_if.Wr_en = 1'b0;
    chk("t3_wr_edge_st2", {31'h0, bus_if.Rd2_st}, {31'h0, BYP});
    chk("t3_wr_edge_d2", bus_if.Rd2_data, BYP ? 32'h55 : 32'hDEADBEEF);
    tick();
    chk("t3_rel_st2", {31'h0, bus_if.Rd2_st}, {31'h0, !BYP});
    chk("t3_rel_d2", bus_if.Rd2_data, 32'h55);
    tick();
    chk("t3_after_st2", {31'h0, bus_if.Rd2_st}, 32'h0);

    // 4: same-edge write and read of r9
    bus_if.Wr_en = 1'b1; bus_if.Wr_addr = 5'd9; bus_if.Wr_data = 32'h3;
    tick();
    bus_if.Wr_data = 32'hA;
    bus_if.Rd1_en = 1'b1; bus_if.Rd1_addr = 5'd9;
    tick();
    bus_if.Wr_en = 1'b0;
    chk("t4_st1", {31'h0, bus_if.Rd1_st}, 32'h1);
    chk("t4_d1", bus_if.Rd1_data, BYP ? 32'hA : 32'h3);
    tick();
    chk("t4_d1_next", bus_if.Rd1_data, 32'hA);
    bus_if.Rd1_en = 1'b0;

    // 5: reserve and write r4 on the same edge; reserve wins
    bus_if.Rsv_en = 1'b1; bus_if.Rsv_addr = 5'd4;
    bus_if.Wr_en = 1'b1; bus_if.Wr_addr = 5'd4; bus_if.Wr_data = 32'h77;
    tick();
    bus_if.Rsv_en = 1'b0; bus_if.Wr_en = 1'b0;
    bus_if.Rd1_en = 1'b1; bus_if.Rd1_addr = 5'd4;
    tick();
    chk("t5_wait_st1", {31'h0, bus_if.Rd1_st}, 32'h0);
    bus_if.Rd1_en = 1'b0;
    tick();
    chk("t5_wait2_st1", {31'h0, bus_if.Rd1_st}, 32'h0);
    bus_if.Wr_en = 1'b1; bus_if.Wr_addr = 5'd4; bus_if.Wr_data = 32'h88;
    tick();
    bus_if.Wr_en = 1'b0;
    chk("t5_wr_edge_st1", {31'h0, bus_if.Rd1_st}, {31'h0, BYP});
    tick();
    chk("t5_rel_st1", {31'h0, bus_if.Rd1_st}, {31'h0, !BYP});
    chk("t5_rel_d1", bus_if.Rd1_data, 32'h88);

    // 6: reset while port 1 waits on r10
    bus_if.Rsv_en = 1'b1; bus_if.Rsv_addr = 5'd10;
    tick();
    bus_if.Rsv_en = 1'b0;
    bus_if.Rd1_en = 1'b1; bus_if.Rd1_addr = 5'd10;
    tick();
    bus_if.Rd1_en = 1'b0;
    chk("t6_wait_st1", {31'h0, bus_if.Rd1_st}, 32'h0);
    tick();
    chk("t6_wait2_st1", {31'h0, bus_if.Rd1_st}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_st1", {31'h0, bus_if.Rd1_st}, 32'h0);
    chk("t6_rst_d1", bus_if.Rd1_data, 32'h0);
    tick();
    rst_n = 1'b1;
    bus_if.Rd1_en = 1'b1; bus_if.Rd1_addr = 5'd10;
    bus_if.Rd2_en = 1'b1; bus_if.Rd2_addr = 5'd7;
    tick();
    chk("t6_post_st1", {31'h0, bus_if.Rd1_st}, 32'h1);
    chk("t6_post_d1", bus_if.Rd1_data, 32'h0);
    chk("t6_post_st2", {31'h0, bus_if.Rd2_st}, 32'h1);
    chk("t6_post_d2", bus_if.Rd2_data, 32'h0);
    bus_if.Rd1_en = 1'b0; bus_if.Rd2_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
